serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_sub_pkg.sv | 12 +
 rtl/full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 108 ++++++++++
 tb/tb_serial_subtractor.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared constants for the bit-serial subtractor: FSM encoding and default operand width.
package serial_sub_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = x - y - bin, bout set when the bit needs to borrow.
module full_subtractor (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = x ^ y ^ bin;
   assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock.
// Optional macro SERIAL_SUB_SATURATE_EN clamps diff to zero whenever the result borrows.
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef SERIAL_SUB_SATURATE_EN
   localparam bit SAT_EN = 1'b1;
`else
   localparam bit SAT_EN = 1'b0;
`endif

   state_t           state, state_nx;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_sh, b_sh, res_sh, diff_q;
   logic             bflop, borrow_q, done_q;
   logic             d_bit, bout_bit;

   function automatic logic [WIDTH-1:0] sat_diff(input logic [WIDTH-1:0] raw,
                                                 input logic brw);
      sat_diff = (SAT_EN && brw) ? '0 : raw;
   endfunction

   full_subtractor u_fs (
      .x    (a_sh[0]),
      .y    (b_sh[0]),
      .bin  (bflop),
      .d    (d_bit),
      .bout (bout_bit)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = RUN;
         RUN:     if (cnt == LAST) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Control and visible result registers; the result is only updated in DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= '0;
         bflop    <= 1'b0;
         done_q   <= 1'b0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: if (start) begin
               cnt   <= '0;
               bflop <= 1'b0;
            end
            RUN: begin
               cnt   <= cnt + 1'b1;
               bflop <= bout_bit;
            end
            DONE: begin
               done_q   <= 1'b1;
               diff_q   <= sat_diff(res_sh, bflop);
               borrow_q <= bflop;
            end
            default: ;
         endcase
      end
   end

   // Operand and partial-result shifters carry no reset; they are loaded on accept.
   always_ff @(posedge clk) begin
      if (state == IDLE && start) begin
         a_sh <= a;
         b_sh <= b;
      end else if (state == RUN) begin
         a_sh   <= a_sh >> 1;
         b_sh   <= b_sh >> 1;
         res_sh <= {d_bit, res_sh[WIDTH-1:1]};
      end
   end

   assign busy   = (state == RUN) || (state == DONE);
   assign done   = done_q;
   assign diff   = diff_q;
   assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed, table-driven bench for serial_subtractor (WIDTH=8), honours SERIAL_SUB_SATURATE_EN.
module tb_serial_subtractor;

   localparam int W = 8;
`ifdef SERIAL_SUB_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] d;
      logic       bo;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst, start;
   logic [W-1:0] a, b, diff;
   logic         busy, done, borrow;
   int           checks = 0;
   int           errors = 0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .diff   (diff),
      .borrow (borrow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [7:0] want(input logic [7:0] d, input logic bo);
      want = (SAT && bo) ? 8'd0 : d;
   endfunction

   // One operation: start pulse, bounded wait for done, latency/busy/stability/result checks.
   task automatic do_op(input logic [7:0] ta, input logic [7:0] tbv, input logic [7:0] ed,
                        input logic eb, input bit disturb, input string tag);
      int         edges = 0;
      int         busy_n = 0;
      int         extra = 0;
      bit         stable = 1'b1;
      logic [7:0] prev;
      @(negedge clk);
      a = ta; b = tbv; start = 1'b1;
      prev = diff;
      while (edges < 40) begin
         @(negedge clk);
         edges++;
         if (!disturb && edges == 1) start = 1'b0;
         if (disturb && edges == 3) begin
            a = ~ta; b = ta;
         end
         if (disturb && edges == 6) start = 1'b0;
         if (busy) busy_n++;
         if (done) break;
         if (diff !== prev) stable = 1'b0;
      end
      start = 1'b0;
      chk({tag, " latency"}, edges, 10);
      chk({tag, " busy_cycles"}, busy_n, 9);
      chk({tag, " diff_stable"}, stable, 1);
      chk({tag, " diff"}, diff, ed);
      chk({tag, " borrow"}, borrow, eb);
      @(negedge clk);
      chk({tag, " done_width"}, done, 0);
      chk({tag, " diff_hold"}, diff, ed);
      if (disturb) begin
         repeat (15) begin
            @(negedge clk);
            if (done) extra++;
         end
         chk({tag, " no_second_done"}, extra, 0);
         chk({tag, " diff_after"}, diff, ed);
      end
   endtask

   initial begin
      vec_t       vecs[10];
      logic [7:0] corner[9];
      int         edges, pulses, last, n;

      vecs[0] = '{8'd200, 8'd55,  8'd145, 1'b0};
      vecs[1] = '{8'd3,   8'd5,   8'd254, 1'b1};
      vecs[2] = '{8'd0,   8'd0,   8'd0,   1'b0};
      vecs[3] = '{8'd255, 8'd0,   8'd255, 1'b0};
      vecs[4] = '{8'd0,   8'd255, 8'd1,   1'b1};
      vecs[5] = '{8'd128, 8'd1,   8'd127, 1'b0};
      vecs[6] = '{8'd1,   8'd128, 8'd129, 1'b1};
      vecs[7] = '{8'd170, 8'd85,  8'd85,  1'b0};
      vecs[8] = '{8'd85,  8'd170, 8'd171, 1'b1};
      vecs[9] = '{8'd255, 8'd255, 8'd0,   1'b0};
      corner  = '{8'd0, 8'd1, 8'd2, 8'd127, 8'd128, 8'd129, 8'd200, 8'd254, 8'd255};

      // Reset wins over a simultaneous start
      rst = 1'b1; start = 1'b1; a = 8'd9; b = 8'd4;
      repeat (3) @(negedge clk);
      chk("reset busy", busy, 0);
      chk("reset done", done, 0);
      chk("reset diff", diff, 0);
      chk("reset borrow", borrow, 0);
      rst = 1'b0; start = 1'b0;
      @(negedge clk);
      chk("idle after reset", busy, 0);

      for (int i = 0; i < 10; i++)
         do_op(vecs[i].a, vecs[i].b, want(vecs[i].d, vecs[i].bo), vecs[i].bo, 1'b0,
               $sformatf("vec%0d", i));

      // start and operand changes while busy
      do_op(8'd77, 8'd33, 8'd44, 1'b0, 1'b1, "busy_start");
      do_op(8'd10, 8'd20, want(8'd246, 1'b1), 1'b1, 1'b1, "busy_start_brw");

      // Reset in the 4th RUN cycle
      do_op(8'd50, 8'd20, 8'd30, 1'b0, 1'b0, "pre_rst_run");
      @(negedge clk);
      a = 8'd90; b = 8'd10; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_run busy", busy, 0);
      chk("rst_run diff", diff, 0);
      chk("rst_run borrow", borrow, 0);
      chk("rst_run done", done, 0);
      rst = 1'b0;
      n = 0;
      repeat (15) begin
         @(negedge clk);
         if (done) n++;
      end
      chk("rst_run no_done", n, 0);
      do_op(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, "zero_after_rst");

      // Reset during DONE suppresses the pulse
      do_op(8'd50, 8'd20, 8'd30, 1'b0, 1'b0, "pre_rst_done");
      @(negedge clk);
      a = 8'd60; b = 8'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(negedge clk);
      chk("rst_done in_done", busy, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_done done", done, 0);
      chk("rst_done diff", diff, 0);
      chk("rst_done busy", busy, 0);
      rst = 1'b0;

      // Back-to-back operations with start held high
      @(negedge clk);
      a = 8'd100; b = 8'd30; start = 1'b1;
      edges = 0; pulses = 0; last = 0;
      while (pulses < 3 && edges < 60) begin
         @(negedge clk);
         edges++;
         if (done) begin
            pulses++;
            if (pulses > 1) chk("b2b spacing", edges - last, 10);
            last = edges;
            chk("b2b diff", diff, 70);
         end
      end
      start = 1'b0;
      chk("b2b pulses", pulses, 3);
      repeat (12) @(negedge clk);
      chk("b2b idle", busy, 0);

      // Corner-value sweep against the arithmetic model
      for (int i = 0; i < 9; i++)
         for (int j = 0; j < 9; j++)
            do_op(corner[i], corner[j], want(corner[i] - corner[j], corner[i] < corner[j]),
                  corner[i] < corner[j], 1'b0, $sformatf("sweep_%0d_%0d", corner[i], corner[j]));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
